// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (diff = a - b, LSB first) with a start/busy/done handshake.
// Optional signed-overflow flag on port ovf when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
`ifdef SUB_SIGNED_OVF_EN
  output logic         ovf,
`endif
  output logic         zero
);

  localparam int CW = $clog2(N);

  // Handshake: start is accepted only on an edge where the state is IDLE or DONE;
  // busy is high exactly in RUN; done pulses for the single DONE cycle and the
  // result outputs are valid from that cycle until the next completing edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sa_q, sb_q;
  logic [N-2:0]   wd_q;
  logic           br_q;
  logic [CW-1:0]  cnt_q;
  logic           accept, last, d_bit, br_next;
  logic [N-1:0]   wd_full;

  assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
  assign last    = (state_q == RUN) && (cnt_q == CW'(N - 1));
  assign d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  // wd_q only keeps the N-1 already-computed bits; the final bit joins on the last edge.
  assign wd_full = {d_bit, wd_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      wd_q   <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      sa_q  <= a;
      sb_q  <= b;
      wd_q  <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      sa_q <= {1'b0, sa_q[N-1:1]};
      sb_q <= {1'b0, sb_q[N-1:1]};
      wd_q <= wd_full[N-1:1];
      br_q <= br_next;
      if (last) begin
        diff   <= wd_full;
        borrow <= br_next;
        zero   <= (wd_full == '0);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic [1:0] msb_q;  // {a[N-1], b[N-1]} of the operation in flight

  always_ff @(posedge clk) begin
    if (rst) begin
      msb_q <= 2'b00;
      ovf   <= 1'b0;
    end else begin
      if (accept) msb_q <= {a[N-1], b[N-1]};
      if (last)   ovf   <= (msb_q[1] ^ msb_q[0]) & (d_bit ^ msb_q[1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8); expected results come from an
// arithmetic model pushed to a queue at issue time and popped on each done pulse.
module tb_serial_subtractor;
  localparam int N = 8;
  localparam int W = N + 3;
`ifdef SUB_SIGNED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, borrow, zero, ovf_obs;
  logic [N-1:0] diff;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
`ifdef SUB_SIGNED_OVF_EN
    .ovf(ovf_obs),
`endif
    .zero(zero)
  );

`ifndef SUB_SIGNED_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // {ovf, zero, borrow, diff}
  function automatic logic [W-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb);
    logic [N-1:0] d;
    logic o;
    d = ma - mb;
    o = OVF_EN & (ma[N-1] ^ mb[N-1]) & (d[N-1] ^ ma[N-1]);
    return {o, (d == '0), (ma < mb), d};
  endfunction

  function automatic logic [W-1:0] observed();
    return {ovf_obs, zero, borrow, diff};
  endfunction

  // Call 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib);
    exp_q.push_back(model(ia, ib));
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high, or after a cycle budget.
  task automatic wait_done(output bit got, output int cycles, output int busy_cycles);
    got = 1'b0;
    cycles = 0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h, want all zero", busy, done, observed());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input logic [N-1:0] ia, input logic [N-1:0] ib, input bit timing);
    bit got;
    int cyc, bcyc;
    logic [W-1:0] exp;
    issue(ia, ib);
    if (timing) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_start: got %b want 1", busy);
      end
    end
    wait_done(got, cyc, bcyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout a=%0d b=%0d: no done within 40 cycles", ia, ib);
    end
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL result a=%0d b=%0d: got %h want %h", ia, ib, observed(), exp);
    end
    if (timing) begin
      checks++;
      if (cyc !== N + 1 || bcyc !== N) begin
        errors++;
        $display("FAIL latency: got done_cycle=%0d busy_cycles=%0d want %0d/%0d", cyc, bcyc, N + 1, N);
      end
    end
    @(posedge clk); #1;
    if (timing) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: got done=%b busy=%b after DONE, want 0/0", done, busy);
      end
    end
  endtask

  task automatic test_hold_zero();
    test_basic(8'd100, 8'd100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (zero !== 1'b1 || diff !== 8'd0) begin
      errors++;
      $display("FAIL zero_hold: got zero=%b diff=%h want 1/00", zero, diff);
    end
  endtask

  task automatic test_start_ignored();
    bit got;
    int cyc, bcyc, d0;
    logic [W-1:0] exp;
    d0 = done_cnt;
    issue(8'd77, 8'd20);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || observed() !== exp) begin
      errors++;
      $display("FAIL start_during_run: got=%b res=%h want %h", got, observed(), exp);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_done: got %0d done pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    issue(8'd10, 8'd3);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    checks++;
    if ({busy, done, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_abort_state: got busy=%b done=%b res=%h want all zero", busy, done, observed());
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL reset_abort_done: got %0d done pulses want 0", done_cnt - d0);
    end
    test_basic(8'd200, 8'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit got;
    int cyc, bcyc;
    logic [W-1:0] exp;
    exp_q.push_back(model(8'h80, 8'h01));
    exp_q.push_back(model(8'd5, 8'd3));
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd5; b = 8'd3;
    wait_done(got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || observed() !== exp || cyc !== N + 1) begin
      errors++;
      $display("FAIL b2b_first: got=%b cyc=%0d res=%h want %h", got, cyc, observed(), exp);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b want 1", busy);
    end
    wait_done(got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || observed() !== exp || cyc !== N + 1) begin
      errors++;
      $display("FAIL b2b_second: got=%b cyc=%0d res=%h want %h", got, cyc, observed(), exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb;
    test_basic(8'd0, 8'd255, 1'b0);
    test_basic(8'd255, 8'd0, 1'b0);
    test_basic(8'd0, 8'd0, 1'b0);
    test_basic(8'h7F, 8'hFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      test_basic(ra, rb, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'd123, 8'd45, 1'b1);
    test_basic(8'd45, 8'd123, 1'b0);
    test_hold_zero();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
